// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_arb_pkg: shared state type, default sizes and helpers
// for the sprite ROM arbiter and its round-robin picker.
package sprite_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_ADDRW     = 10;
    localparam int DEF_DATAW     = 3;
    localparam int DEF_ROM_LAT   = 1;
    localparam int DEF_MAX_BURST = 8;

    function automatic int ptr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: engine-side request/return bundle
// shared by all sprite engines and the ROM arbiter.
interface sprite_rom_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int ADDRW = 10,
    parameter int DATAW = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*ADDRW-1:0] addr;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rd_valid;
    logic [DATAW-1:0]      rd_data;

    modport master (
        output req, lock, addr,
        input  gnt, rd_valid, rd_data
    );

    modport slave (
        input  req, lock, addr,
        output gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder; the first
// requester at or after ptr (mod N) wins.
module rr_pick
    import sprite_arb_pkg::*;
#(
    parameter int N  = DEF_NREQ,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);
    int j;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx    = '0;
        onehot = '0;
        j      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) idx = PW'(j);
        end
        any = |req;
        if (any) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one sprite ROM among N engines.
// Define ARB_LINE_SYNC_EN to realign the rotation to engine 0 each scanline.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int ADDRW     = DEF_ADDRW,
    parameter int DATAW     = DEF_DATAW,
    parameter int ROM_LAT   = DEF_ROM_LAT,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                line,
    sprite_rom_arbiter_if.slave bus,
    output logic [ADDRW-1:0]    rom_addr,
    input  logic [DATAW-1:0]    rom_data,
    output logic                busy
);
    localparam int PW = ptr_w(NREQ);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [7:0] beat_q, beat_d;
    logic [ADDRW-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_LAT-1:0][NREQ-1:0] vld_q, vld_d;

    logic [NREQ-1:0] gnt_c, pick_oh;
    logic [PW-1:0] pick_idx, arb_ptr;
    logic pick_any, arb_en, hold_go, line_sync;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + PW'(1);
    endfunction

`ifdef ARB_LINE_SYNC_EN
    assign line_sync = line;
`else
    logic unused_line;
    assign unused_line = line;
    assign line_sync   = 1'b0;
`endif

    // Leaving HOLD re-arbitrates at once with the old owner ranked last.
    assign arb_ptr = (state_q == HOLD) ? next_idx(owner_q) : ptr_q;
    assign hold_go = bus.req[owner_q] & bus.lock[owner_q]
                   & (beat_q < BURST_MAX);

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (arb_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        beat_d     = beat_q;
        rom_addr_d = rom_addr_q;
        gnt_c      = '0;
        arb_en     = 1'b0;
        unique case (state_q)
            ARB: arb_en = 1'b1;
            HOLD: begin
                if (hold_go) begin
                    gnt_c[owner_q] = 1'b1;
                    rom_addr_d = bus.addr[int'(owner_q)*ADDRW +: ADDRW];
                    beat_d = (beat_q == 8'hff) ? beat_q : beat_q + 8'd1;
                    if (line_sync) state_d = ARB;
                end else begin
                    state_d = ARB;
                    arb_en  = 1'b1;
                end
            end
        endcase
        if (arb_en && pick_any) begin
            gnt_c      = pick_oh;
            rom_addr_d = bus.addr[int'(pick_idx)*ADDRW +: ADDRW];
            ptr_d      = next_idx(pick_idx);
            if (bus.lock[pick_idx]) begin
                state_d = HOLD;
                owner_d = pick_idx;
                beat_d  = 8'd1;
            end
        end
        if (line_sync) ptr_d = '0;
    end

    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = gnt_c;
        for (int k = 1; k < ROM_LAT; k++) vld_d[k] = vld_q[k-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            beat_q     <= '0;
            rom_addr_q <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            beat_q     <= beat_d;
            rom_addr_q <= rom_addr_d;
            vld_q      <= vld_d;
        end
    end

    assign bus.gnt      = rst_n ? gnt_c : '0;
    assign bus.rd_valid = rst_n ? vld_q[ROM_LAT-1] : '0;
    assign bus.rd_data  = rom_data;
    assign rom_addr     = rst_n ? rom_addr_d : '0;
    assign busy         = rst_n && (state_q == HOLD);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: vector table, directed corner cases and random
// traffic against a rule-level model, on ROM_LAT=1 and ROM_LAT=2 instances.
module tb_sprite_rom_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 3;
    localparam int MB = 8;
`ifdef ARB_LINE_SYNC_EN
    localparam bit LS = 1'b1;
`else
    localparam bit LS = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [N-1:0] gnt;
        logic         busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] lock = '0;
    logic [AW-1:0] a [N];
    logic [AW-1:0] rom_addr1, rom_addr2, ra1, ra2a, ra2b;
    logic [DW-1:0] rom_data1, rom_data2;
    logic busy1, busy2;

    int total = 0;
    int bad = 0;

    int m_ptr = 0, m_owner = 0, m_beat = 0;
    bit m_hold = 1'b0;
    logic [AW-1:0] m_last = '0;
    logic [N-1:0] vh [2];
    logic [AW-1:0] ah [2];
    logic [N-1:0] cur_gnt;
    vec_t tv [$];

    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.NREQ(N), .ADDRW(AW), .DATAW(DW)) b1 ();
    sprite_rom_arbiter_if #(.NREQ(N), .ADDRW(AW), .DATAW(DW)) b2 ();

    assign b1.req  = req;
    assign b2.req  = req;
    assign b1.lock = lock;
    assign b2.lock = lock;
    assign b1.addr = {a[3], a[2], a[1], a[0]};
    assign b2.addr = {a[3], a[2], a[1], a[0]};

    sprite_rom_arbiter #(.NREQ(N), .ADDRW(AW), .DATAW(DW),
                         .ROM_LAT(1), .MAX_BURST(MB)) dut1 (
        .clk(clk), .rst_n(rst_n), .line(line), .bus(b1),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .busy(busy1));

    sprite_rom_arbiter #(.NREQ(N), .ADDRW(AW), .DATAW(DW),
                         .ROM_LAT(2), .MAX_BURST(MB)) dut2 (
        .clk(clk), .rst_n(rst_n), .line(line), .bus(b2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .busy(busy2));

    function automatic logic [DW-1:0] romf(input logic [AW-1:0] x);
        return x[2:0] ^ x[5:3] ^ x[8:6] ^ {2'b00, x[9]};
    endfunction

    // Synchronous ROMs with one and two cycles of read latency.
    always @(posedge clk) begin
        ra1  <= rom_addr1;
        ra2a <= rom_addr2;
        ra2b <= ra2a;
    end
    assign rom_data1 = romf(ra1);
    assign rom_data2 = romf(ra2b);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One cycle of the reference: who should win, then compare.
    task automatic model_check();
        int g, p;
        logic [N-1:0] ev;
        logic [AW-1:0] ea;
        logic eb;
        eb = rst_n && m_hold;
        g = -1;
        if (!rst_n) begin
            m_ptr = 0; m_hold = 0; m_owner = 0; m_beat = 0; m_last = '0;
        end else if (m_hold && req[m_owner] && lock[m_owner] && m_beat < MB) begin
            g = m_owner;
            m_beat++;
            if (LS && line) m_hold = 0;
        end else begin
            p = m_hold ? (m_owner + 1) % N : m_ptr;
            m_hold = 0;
            for (int k = 0; k < N; k++)
                if (g < 0 && req[(p + k) % N]) g = (p + k) % N;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (lock[g]) begin
                    m_hold = 1; m_owner = g; m_beat = 1;
                end
            end
        end
        if (rst_n && LS && line) m_ptr = 0;
        ev = '0;
        if (g >= 0) ev[g] = 1'b1;
        ea = !rst_n ? '0 : (g >= 0) ? a[g] : m_last;
        m_last = ea;
        cur_gnt = ev;

        chk("gnt1", b1.gnt, ev);
        chk("gnt2", b2.gnt, ev);
        chk("rom_addr1", rom_addr1, ea);
        chk("rom_addr2", rom_addr2, ea);
        chk("busy1", busy1, eb);
        chk("busy2", busy2, eb);
        chk("rd_valid1", b1.rd_valid, rst_n ? vh[0] : '0);
        chk("rd_valid2", b2.rd_valid, rst_n ? vh[1] : '0);
        if (rst_n && vh[0] != 0) chk("rd_data1", b1.rd_data, romf(ah[0]));
        if (rst_n && vh[1] != 0) chk("rd_data2", b2.rd_data, romf(ah[1]));

        if (!rst_n) begin
            vh[0] = '0; vh[1] = '0;
        end else begin
            vh[1] = vh[0]; vh[0] = ev;
            ah[1] = ah[0]; ah[0] = ea;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N-1:0] g, input logic b, input int n);
        vec_t v;
        v.req = r; v.lock = l; v.gnt = g; v.busy = b;
        for (int i = 0; i < n; i++) tv.push_back(v);
    endtask

    initial begin
        vh[0] = '0; vh[1] = '0;
        ah[0] = '0; ah[1] = '0;
        a[0] = 10'h0a3; a[1] = 10'h1c4; a[2] = 10'h155; a[3] = 10'h2e7;

        add(4'b1111, 4'b0000, 4'b0001, 1'b0, 1);
        add(4'b1111, 4'b0000, 4'b0010, 1'b0, 1);
        add(4'b1111, 4'b0000, 4'b0100, 1'b0, 1);
        add(4'b1111, 4'b0000, 4'b1000, 1'b0, 1);
        add(4'b1111, 4'b0000, 4'b0001, 1'b0, 1);
        add(4'b0100, 4'b0000, 4'b0100, 1'b0, 3);
        add(4'b1111, 4'b0010, 4'b1000, 1'b0, 1);
        add(4'b1111, 4'b0010, 4'b0001, 1'b0, 1);
        add(4'b1111, 4'b0010, 4'b0010, 1'b0, 1);
        add(4'b1111, 4'b0010, 4'b0010, 1'b1, 7);
        add(4'b1111, 4'b0010, 4'b0100, 1'b1, 1);
        add(4'b1111, 4'b1000, 4'b1000, 1'b0, 1);
        add(4'b1111, 4'b1000, 4'b1000, 1'b1, 2);
        add(4'b1111, 4'b0000, 4'b0001, 1'b1, 1);
        add(4'b1111, 4'b0000, 4'b0010, 1'b0, 1);
        add(4'b0001, 4'b1110, 4'b0001, 1'b0, 2);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1);

        // Reset state with requests pending.
        req = 4'b1111;
        lock = 4'b0010;
        to_pos();
        for (int i = 0; i < 2; i++) begin
            at_neg();
            to_pos();
        end
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            req = tv[i].req;
            lock = tv[i].lock;
            at_neg();
            chk($sformatf("vec%0d_gnt", i), b1.gnt, tv[i].gnt);
            chk($sformatf("vec%0d_busy", i), busy1, tv[i].busy);
            to_pos();
        end

        // Line pulse with ptr sitting at engine 2.
        req = 4'b0010; lock = '0;
        at_neg(); to_pos();
        req = '0; line = 1'b1;
        at_neg(); to_pos();
        req = 4'b1111; line = 1'b0;
        at_neg();
        chk("line_gnt", b1.gnt, LS ? 4'b0001 : 4'b0100);
        to_pos();

        // Reset in the middle of a locked burst.
        lock = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            at_neg(); to_pos();
        end
        rst_n = 1'b0;
        at_neg();
        chk("rst_gnt", b2.gnt, 4'b0000);
        chk("rst_rd_valid", b2.rd_valid, 4'b0000);
        chk("rst_busy", busy2, 1'b0);
        chk("rst_rom_addr", rom_addr2, 10'h000);
        to_pos();
        rst_n = 1'b1;
        lock = '0;
        at_neg();
        chk("resume_gnt", b2.gnt, 4'b0001);
        chk("resume_rd_valid_a", b2.rd_valid, 4'b0000);
        to_pos();
        at_neg();
        chk("resume_rd_valid_b", b2.rd_valid, 4'b0000);
        chk("resume_rd_valid1", b1.rd_valid, 4'b0001);
        to_pos();
        at_neg();
        chk("resume_rd_valid_c", b2.rd_valid, 4'b0001);
        to_pos();

        for (int c = 0; c < 800; c++) begin
            req = N'($urandom | $urandom);
            if ($urandom_range(0, 3) == 0) lock = N'($urandom);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1 && cur_gnt[i]) a[i] = AW'($urandom);
            line = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            at_neg();
            to_pos();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
